// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes, flag positions, FIFO entry layout.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef struct packed {
        logic [3:0] result;
        logic [1:0] sel;
        logic [3:0] flags;
    } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from an ALU result, its carry, opcode and operand signs.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [3:0] result,
    input  logic       carry,
    input  logic [1:0] sel,
    input  logic       a_msb,
    input  logic       b_msb,
    output logic [3:0] flags
);

    always_comb begin
        flags        = '0;
        flags[FLG_N] = result[3];
        flags[FLG_Z] = (result == 4'd0);
        case (sel)
            OP_ADD: begin
                flags[FLG_C] = carry;
                flags[FLG_V] = (a_msb == b_msb) && (result[3] != a_msb);
            end
            OP_SUB: begin
                // carry set means no borrow
                flags[FLG_C] = carry;
                flags[FLG_V] = (a_msb != b_msb) && (result[3] != a_msb);
            end
            default: begin
                flags[FLG_C] = 1'b0;
                flags[FLG_V] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result FIFO behind the ALU with per-entry flags, sticky C/V and a retired counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_result,
    input  logic             in_carry,
    input  logic [1:0]       in_sel,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic [1:0]       out_sel,
    output logic [3:0]       out_flags,
    output logic             sticky_c,
    output logic             sticky_v,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [3:0]    flags;
    logic          push, pop;
    entry_t        head;

    alu_flag_gen u_flag_gen (
        .result (in_result),
        .carry  (in_carry),
        .sel    (in_sel),
        .a_msb  (in_a_msb),
        .b_msb  (in_b_msb),
        .flags  (flags)
    );

    assign in_ready  = (occ != FULL_OCC);
    assign out_valid = (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is read straight from storage through the registered read pointer.
    assign head       = mem[rd_ptr];
    assign out_result = head.result;
    assign out_sel    = head.sel;
    assign out_flags  = head.flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            sticky_c    <= 1'b0;
            sticky_v    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{result: in_result, sel: in_sel, flags: flags};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
            // A push in the same cycle as a clear still sets the flag.
            sticky_c <= (sticky_clr ? 1'b0 : sticky_c) | (push & flags[FLG_C]);
            sticky_v <= (sticky_clr ? 1'b0 : sticky_v) | (push & flags[FLG_V]);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [3:0]       in_result;
    logic             in_carry;
    logic [1:0]       in_sel;
    logic             in_a_msb, in_b_msb;
    logic             out_valid, out_ready;
    logic [3:0]       out_result;
    logic [1:0]       out_sel;
    logic [3:0]       out_flags;
    logic             sticky_c, sticky_v, sticky_clr;
    logic [CNT_W-1:0] retired_cnt;

    alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry), .in_sel(in_sel),
        .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_sel(out_sel), .out_flags(out_flags),
        .sticky_c(sticky_c), .sticky_v(sticky_v), .sticky_clr(sticky_clr),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [1:0] s;
        logic [3:0] f;
    } ent_t;

    ent_t mq[$];
    logic m_sc, m_sv;
    int   m_cnt;
    int   tests = 0;
    int   failed = 0;
    logic [3:0] cur_flags;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: real 4-bit arithmetic, flags from signed range and unsigned carry.
    task automatic set_op(input int a, input int b, input logic [1:0] sel, input logic junk_c);
        int r, sa, sb, sres;
        logic c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        c = 1'b0; v = 1'b0;
        case (sel)
            2'b00: begin r = a + b;            c = (r > 15);  sres = sa + sb; v = (sres > 7 || sres < -8); end
            2'b01: begin r = a + (15 - b) + 1; c = (a >= b);  sres = sa - sb; v = (sres > 7 || sres < -8); end
            2'b10: begin r = a & b; end
            default: begin r = a | b; end
        endcase
        r = r % 16;
        in_result = 4'(r);
        in_carry  = (sel[1]) ? junk_c : c;
        in_sel    = sel;
        in_a_msb  = (a >= 8);
        in_b_msb  = (b >= 8);
        cur_flags = {(r >= 8), (r == 0), (sel[1] ? 1'b0 : c), v};
    endtask

    task automatic tick();
        logic mpush, mpop;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_sc = 0; m_sv = 0; m_cnt = 0;
        end else begin
            mpush = in_valid && (mq.size() < DEPTH);
            mpop  = out_ready && (mq.size() > 0);
            if (mpop) begin
                void'(mq.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (mpush) begin
                e.r = in_result; e.s = in_sel; e.f = cur_flags;
                mq.push_back(e);
            end
            m_sc = (sticky_clr ? 1'b0 : m_sc) | (mpush & cur_flags[1]);
            m_sv = (sticky_clr ? 1'b0 : m_sv) | (mpush & cur_flags[0]);
        end
        #1;
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("out_result", out_result, mq[0].r);
            chk("out_sel", out_sel, mq[0].s);
            chk("out_flags", out_flags, mq[0].f);
        end
        chk("sticky_c", sticky_c, m_sc);
        chk("sticky_v", sticky_v, m_sv);
        chk("retired_cnt", retired_cnt, m_cnt);
    endtask

    initial begin
        logic [3:0] held;
        rst = 1; in_valid = 0; out_ready = 0; sticky_clr = 0;
        set_op(0, 0, 2'b00, 1'b0);
        m_sc = 0; m_sv = 0; m_cnt = 0;
        tick(); tick();
        chk("rst_out_result", out_result, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_flags", out_flags, 0);
        rst = 0;
        tick();

        // 8+8: result 0, carry, overflow
        set_op(8, 8, 2'b00, 1'b0); in_valid = 1;
        tick();
        in_valid = 0;
        chk("add_flags", out_flags, 4'b0111);
        chk("add_result", out_result, 4'b0000);
        chk("add_sticky", {sticky_c, sticky_v}, 2'b11);
        out_ready = 1; tick(); out_ready = 0;

        // 7-(-1): overflow into negative; head must hold while stalled
        set_op(7, 15, 2'b01, 1'b0); in_valid = 1;
        tick();
        in_valid = 0;
        chk("sub_flags", out_flags, 4'b1001);
        held = out_flags;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_flags", out_flags, held);
        end
        out_ready = 1; tick(); out_ready = 0;
        chk("retired_after_sub", retired_cnt, 2);

        // Fill, refuse a third, pop while full, then drain in order
        for (int i = 0; i < 3; i++) begin
            set_op(i + 1, 2, 2'b00, 1'b0); in_valid = 1; tick();
        end
        chk("full_in_ready", in_ready, 0);
        set_op(9, 9, 2'b11, 1'b0); out_ready = 1; tick();
        chk("no_push_when_full", out_result, 4'd4);
        in_valid = 0; tick(); tick();
        out_ready = 0;

        // Occupancy 1 streaming with results 1..10
        set_op(0, 1, 2'b11, 1'b0); in_valid = 1; tick();
        out_ready = 1;
        for (int i = 1; i <= 10; i++) begin
            set_op(i, 0, 2'b11, 1'b0); tick();
        end
        in_valid = 0; tick(); out_ready = 0;

        // Sticky clear vs push priority, and logic ops never set C
        sticky_clr = 1; tick(); sticky_clr = 0;
        set_op(15, 1, 2'b00, 1'b0); in_valid = 1; sticky_clr = 1; tick();
        chk("clr_push_wins", sticky_c, 1);
        in_valid = 0; tick();
        chk("clr_alone", sticky_c, 0);
        sticky_clr = 0;
        set_op(12, 10, 2'b10, 1'b1); in_valid = 1; out_ready = 1; tick();
        in_valid = 0;
        chk("and_c_zero", out_flags[1], 0);
        chk("and_sticky", sticky_c, 0);
        tick(); out_ready = 0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            set_op($urandom_range(15), $urandom_range(15), 2'($urandom_range(3)), 1'($urandom_range(1)));
            in_valid   = 1'($urandom_range(1));
            out_ready  = 1'($urandom_range(1));
            sticky_clr = ($urandom_range(7) == 0);
            tick();
        end
        sticky_clr = 0; out_ready = 0;

        // Fill, then reset with in_valid held high
        set_op(8, 8, 2'b00, 1'b0); in_valid = 1; tick(); tick();
        rst = 1; tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_sticky", {sticky_c, sticky_v}, 0);
        chk("mid_rst_cnt", retired_cnt, 0);
        rst = 0; in_valid = 0; tick();
        chk("no_capture_in_rst", out_valid, 0);

        // Counter wrap after 2^CNT_W pops
        set_op(3, 3, 2'b11, 1'b0); in_valid = 1; tick();
        out_ready = 1;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) tick();
        in_valid = 0; tick();
        chk("cnt_wrap", retired_cnt, 0);
        out_ready = 0; tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
